oled_byte_sequencer: RTL and testbench

Byte-level sequencer sitting directly upstream of the SSD1306 SPI byte master. After power-up it pulses the panel reset pin and issues the fixed 25-byte SSD1306 init command list. On each frame request it sends a 6-byte address-window command and streams 1024 display bytes read from an external framebuffer. It drives the master's `send_en`/`send_res`/`send_data` inputs and paces itself purely on the master's `busy`.

---
 rtl/oled_pkg.sv | 37 +++
 rtl/oled_cmd_rom.sv | 22 ++
 rtl/oled_byte_sequencer.sv | 155 +++++++++++++++
 tb/tb_oled_byte_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 byte sequencer: state/phase
// encodings, data/command flag values and the two fixed command lists.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_WIN,
        ST_FRAME
    } state_t;

    // Per-byte handshake phase inside INIT/WIN/FRAME.
    typedef enum logic [1:0] {
        PH_FETCH,
        PH_LOAD,
        PH_EN,
        PH_WAIT
    } phase_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int INIT_LEN = 25;
    localparam logic [7:0] INIT_BYTES [0:INIT_LEN-1] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    localparam int WIN_LEN = 6;
    localparam logic [7:0] WIN_BYTES [0:WIN_LEN-1] = '{
        8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

endpackage

// File: rtl/oled_cmd_rom.sv
// Combinational command ROM: selects the init list or the address-window list
// and returns the byte at the given index (0 beyond the end of a list).
module oled_cmd_rom
    import oled_pkg::*;
(
    input  logic [4:0] i_index,
    input  logic       i_sel_win,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        if (i_sel_win) begin
            if (i_index < 5'(WIN_LEN)) begin
                o_byte = WIN_BYTES[i_index[2:0]];
            end
        end else if (i_index < 5'(INIT_LEN)) begin
            o_byte = INIT_BYTES[i_index];
        end
    end

endmodule

// File: rtl/oled_byte_sequencer.sv
// SSD1306 byte sequencer: panel reset, init list, then window + framebuffer per frame.
// Define OLED_TEST_PATTERN_EN to stream an internal checkerboard instead of fb_data.
module oled_byte_sequencer
    import oled_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int RST_US      = 10,
    parameter int RST_WAIT_US = 100,
    parameter int FB_BYTES    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       byte_busy,
    output logic       byte_en,
    output logic       byte_dc,
    output logic [7:0] byte_data,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       oled_rst_n,
    output logic       init_done,
    output logic       frame_done,
    output logic       seq_busy
);

    localparam int HOLD_N = CLK_FRE * RST_US;
    localparam int WAIT_N = CLK_FRE * RST_WAIT_US;
    localparam int MAX_N  = (HOLD_N > WAIT_N) ? HOLD_N : WAIT_N;
    localparam int CNT_W  = ($clog2(MAX_N) > 16) ? $clog2(MAX_N) : 16;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_N - 1);
    localparam logic [9:0]       FB_LAST   = 10'(FB_BYTES - 1);

    state_t           r_state, w_state_next;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_idx;
    logic             r_pending;
    logic             r_byte_en, r_byte_dc, r_frame_done;
    logic [7:0]       r_byte_data;
    logic [9:0]       r_fb_addr;
    logic             w_sending, w_byte_done;
    logic [7:0]       w_rom_byte, w_frame_byte;
    logic [9:0]       w_fb_addr_inc;

    oled_cmd_rom u_rom (
        .i_index   (r_idx),
        .i_sel_win (r_state == ST_WIN),
        .o_byte    (w_rom_byte)
    );

    assign w_sending     = (r_state == ST_INIT) || (r_state == ST_WIN) || (r_state == ST_FRAME);
    assign w_byte_done   = w_sending && (r_phase == PH_WAIT) && !byte_busy;
    assign w_fb_addr_inc = (r_fb_addr == FB_LAST) ? 10'd0 : r_fb_addr + 10'd1;

`ifdef OLED_TEST_PATTERN_EN
    assign w_frame_byte = r_fb_addr[0] ? 8'h55 : 8'hAA;
`else
    assign w_frame_byte = fb_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RST_HOLD: if (r_cnt == HOLD_LAST) w_state_next = ST_RST_WAIT;
            ST_RST_WAIT: if (r_cnt == WAIT_LAST) w_state_next = ST_INIT;
            ST_INIT:     if (w_byte_done && r_idx == 5'(INIT_LEN - 1)) w_state_next = ST_IDLE;
            ST_IDLE:     if (frame_start || r_pending) w_state_next = ST_WIN;
            ST_WIN:      if (w_byte_done && r_idx == 5'(WIN_LEN - 1)) w_state_next = ST_FRAME;
            ST_FRAME:    if (w_byte_done && r_fb_addr == FB_LAST) w_state_next = ST_IDLE;
            default:     w_state_next = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= PH_LOAD;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_byte_en    <= 1'b0;
            r_byte_dc    <= DC_CMD;
            r_byte_data  <= 8'h00;
            r_fb_addr    <= 10'd0;
            r_frame_done <= 1'b0;
        end else begin
            if ((r_state == ST_RST_HOLD || r_state == ST_RST_WAIT) && w_state_next == r_state) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            r_frame_done <= (r_state == ST_FRAME) && (w_state_next == ST_IDLE);

            // Only one request can wait; requests arriving in IDLE start a frame directly.
            if (r_state == ST_IDLE) begin
                if (w_state_next == ST_WIN) r_pending <= 1'b0;
            end else if (frame_start) begin
                r_pending <= 1'b1;
            end

            if (r_state == ST_FRAME && w_byte_done) begin
                r_fb_addr <= w_fb_addr_inc;
            end

            if (w_state_next != r_state) begin
                r_idx     <= '0;
                r_byte_en <= 1'b0;
                r_phase   <= (w_state_next == ST_FRAME) ? PH_FETCH : PH_LOAD;
            end else if (w_sending) begin
                case (r_phase)
                    PH_FETCH: r_phase <= PH_LOAD;
                    PH_LOAD: begin
                        r_byte_data <= (r_state == ST_FRAME) ? w_frame_byte : w_rom_byte;
                        r_byte_dc   <= (r_state == ST_FRAME) ? DC_DATA : DC_CMD;
                        r_byte_en   <= 1'b1;
                        r_phase     <= PH_EN;
                    end
                    PH_EN: begin
                        if (byte_busy) begin
                            r_byte_en <= 1'b0;
                            r_phase   <= PH_WAIT;
                        end
                    end
                    default: begin
                        if (!byte_busy) begin
                            r_idx   <= r_idx + 5'd1;
                            r_phase <= (r_state == ST_FRAME) ? PH_FETCH : PH_LOAD;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        byte_en    = r_byte_en;
        byte_dc    = r_byte_dc;
        byte_data  = r_byte_data;
        fb_addr    = r_fb_addr;
        frame_done = r_frame_done;
        oled_rst_n = (r_state != ST_RST_HOLD);
        init_done  = (r_state == ST_IDLE) || (r_state == ST_WIN) || (r_state == ST_FRAME);
        seq_busy   = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_oled_byte_sequencer.sv
// Bench for oled_byte_sequencer: randomized SPI master model, framebuffer model and a
// byte-stream scoreboard built from the command lists and framebuffer contents.
module tb_oled_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       byte_busy;
    logic       byte_en, byte_dc;
    logic [7:0] byte_data;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       oled_rst_n, init_done, frame_done, seq_busy;

    always #5 clk = ~clk;

    oled_byte_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .byte_busy   (byte_busy),
        .byte_en     (byte_en),
        .byte_dc     (byte_dc),
        .byte_data   (byte_data),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .oled_rst_n  (oled_rst_n),
        .init_done   (init_done),
        .frame_done  (frame_done),
        .seq_busy    (seq_busy)
    );

    typedef struct {
        logic       dc;
        logic [7:0] data;
    } byte_t;

    typedef struct {
        int extra_starts;
        bit addr_fill;
        int exp_frames;
    } vec_t;

    logic [7:0] init_ref [0:24] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };
    logic [7:0] win_ref [0:5] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    logic [7:0] mem [0:1023];
    byte_t      got_q[$];
    byte_t      exp_q[$];

    int total = 0;
    int bad   = 0;
    int md_min, md_max, mh_min, mh_max;
    int stab_bad = 0;
    int rst_epoch = 0;
    int fd_count = 0;
    int fd_busy_bad = 0;

    // Framebuffer with one cycle of read latency.
    always @(posedge clk) fb_data <= mem[fb_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    initial forever begin
        @(negedge rst_n);
        rst_epoch++;
    end

    initial forever begin
        @(negedge clk);
        if (frame_done === 1'b1) begin
            fd_count++;
            if (seq_busy !== 1'b0) fd_busy_bad++;
        end
    end

    // SPI byte master: accept after a delay, hold busy, then release.
    initial begin : master
        int d, h, ep;
        byte_t cap;
        byte_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (byte_en === 1'b1 && rst_n === 1'b1) begin
                d = $urandom_range(md_max, md_min);
                repeat (d) @(negedge clk);
                cap.dc   = byte_dc;
                cap.data = byte_data;
                ep       = rst_epoch;
                got_q.push_back(cap);
                byte_busy = 1'b1;
                h = $urandom_range(mh_max, mh_min);
                repeat (h) @(negedge clk);
                if (ep == rst_epoch &&
                    (byte_data !== cap.data || byte_dc !== cap.dc || byte_en !== 1'b0)) begin
                    stab_bad++;
                end
                byte_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " byte_en"},    32'(byte_en),    32'd0);
        chk({tag, " byte_dc"},    32'(byte_dc),    32'd0);
        chk({tag, " byte_data"},  32'(byte_data),  32'd0);
        chk({tag, " fb_addr"},    32'(fb_addr),    32'd0);
        chk({tag, " oled_rst_n"}, 32'(oled_rst_n), 32'd0);
        chk({tag, " init_done"},  32'(init_done),  32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, " seq_busy"},   32'(seq_busy),   32'd1);
    endtask

    function automatic logic [7:0] model_frame_byte(input int i);
`ifdef OLED_TEST_PATTERN_EN
        return (i % 2 == 1) ? 8'h55 : 8'hAA;
`else
        return mem[i];
`endif
    endfunction

    task automatic fill_mem(input bit addr_fill);
        for (int a = 0; a < 1024; a++) begin
`ifdef OLED_TEST_PATTERN_EN
            mem[a] = 8'hFF;
`else
            mem[a] = addr_fill ? 8'(a) : 8'($urandom);
`endif
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < 25; i++) exp_q.push_back('{1'b0, init_ref[i]});
    endtask

    task automatic push_frame();
        for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, win_ref[i]});
        for (int i = 0; i < 1024; i++) exp_q.push_back('{1'b1, model_frame_byte(i)});
    endtask

    task automatic cmp_stream(input string name);
        int mism, first, n;
        mism = 0;
        first = -1;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i].dc !== exp_q[i].dc || got_q[i].data !== exp_q[i].data) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        chk({name, " byte count"}, 32'(got_q.size()), 32'(exp_q.size()));
        chk($sformatf("%s byte mismatches (first at %0d)", name, first), 32'(mism), 32'd0);
    endtask

    task automatic wait_frames(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (!(fd_count >= n && seq_busy === 1'b0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, " completes within budget"}, 32'(c < budget), 32'd1);
    endtask

    task automatic wait_level(input string name, ref logic sig, input int budget);
        int c;
        c = 0;
        while (sig !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({name, " within budget"}, 32'(c < budget), 32'd1);
    endtask

    initial begin : main
        vec_t vecs [0:2];
        int lo, hi, g;

        vecs[0] = '{0, 1'b1, 1};
        vecs[1] = '{3, 1'b0, 2};
        vecs[2] = '{1, 1'b0, 2};

        rst_n = 1'b0;
        frame_start = 1'b0;
        md_min = 4; md_max = 4; mh_min = 40; mh_max = 40;
        fill_mem(1'b1);
        tick(3);
        check_reset("por");

        @(posedge clk);
        #1 rst_n = 1'b1;
        lo = 0;
        @(negedge clk);
        while (oled_rst_n !== 1'b1 && lo < 2000) begin
            lo++;
            @(negedge clk);
        end
        chk("oled_rst_n low cycles", 32'(lo), 32'd500);
        hi = 0;
        while (byte_en !== 1'b1 && hi < 6000) begin
            hi++;
            @(negedge clk);
        end
        chk($sformatf("settle cycles %0d within 5000..5002", hi), 32'(hi >= 5000 && hi <= 5002), 32'd1);
        wait_level("init_done", init_done, 4000);
        exp_q.delete();
        push_init();
        cmp_stream("init");
        chk("seq_busy after init", 32'(seq_busy), 32'd0);
        $display("init: %0d bytes captured, init_done=%0b", got_q.size(), init_done);

        md_min = 0; md_max = 1; mh_min = 1; mh_max = 2;
        for (int v = 0; v < 3; v++) begin
            got_q.delete();
            exp_q.delete();
            fd_count = 0;
            fill_mem(vecs[v].addr_fill);
            for (int f = 0; f < vecs[v].exp_frames; f++) push_frame();
            pulse_start();
            for (int e = 0; e < vecs[v].extra_starts; e++) begin
                tick($urandom_range(900, 50));
                pulse_start();
            end
            wait_frames($sformatf("vec%0d", v), vecs[v].exp_frames, 13000 * vecs[v].exp_frames);
            tick(40);
            chk($sformatf("vec%0d frame_done pulses", v), 32'(fd_count), 32'(vecs[v].exp_frames));
            cmp_stream($sformatf("vec%0d stream", v));
            $display("vec %0d: extra_starts=%0d frames=%0d bytes=%0d", v,
                     vecs[v].extra_starts, fd_count, got_q.size());
        end

        // Reset in the middle of the frame, once byte 300 has been accepted.
        got_q.delete();
        fill_mem(1'b1);
        pulse_start();
        g = 0;
        while (got_q.size() < 307 && g < 8000) begin
            @(negedge clk);
            g++;
        end
        chk("reached frame byte 300", 32'(g < 8000), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("midframe");
        $display("midframe reset: asserted after %0d bytes", got_q.size());
        tick(3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        fd_count = 0;

        // Requests made before init completes: one queued, the other dropped.
        wait_level("oled_rst_n release", oled_rst_n, 1000);
        pulse_start();
        wait_level("first init byte_en", byte_en, 6000);
        pulse_start();
        wait_level("re-init done", init_done, 3000);
        g = 0;
        while (byte_en !== 1'b1 && g < 10) begin
            g++;
            @(negedge clk);
        end
        chk($sformatf("queued frame starts %0d cycles after init_done", g), 32'(g <= 3), 32'd1);
        wait_frames("queued frame", 1, 13000);
        tick(50);
        chk("queued frame_done pulses", 32'(fd_count), 32'd1);
        push_init();
        push_frame();
        cmp_stream("reinit+frame");
        $display("reinit: frames=%0d bytes=%0d", fd_count, got_q.size());

        chk("byte data/dc stable during handshake", 32'(stab_bad), 32'd0);
        chk("seq_busy low with frame_done", 32'(fd_busy_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
